conv33_window_gen: RTL and testbench
====================================

CONV33_WINDOW_GEN -- requirements
Module: conv33_window_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 28, image width in pixels (legal range 3..256).
REQ-003 SHALL have parameter IMG_H, default 28, image height in pixels (legal range 3..256).
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins a frame.
REQ-007 SHALL have port done  output  1  one-cycle pulse after the last window of a frame is taken.
REQ-008 SHALL have port pix_valid_in  input  1  upstream pixel valid.
REQ-009 SHALL have port pix_ready_out  output  1  pixel accepted when pix_valid_in and pix_ready_out are both high.
REQ-010 SHALL have port pix_data  input  DATA_WIDTH  raster-order pixel, row-major, left to right.
REQ-011 SHALL have port win_valid_out  output  1  window valid toward the 3x3 convolution input stage.
REQ-012 SHALL have port win_ready_in  input  1  downstream takes the window when win_valid_out and win_ready_in are both high.
REQ-013 SHALL have ports win_0_0 .. win_2_2  output  DATA_WIDTH each  3x3 window; win_r_c is row r (0 = oldest/top), column c (0 = leftmost).

Function
REQ-014 SHALL implement states IDLE, RUN and FLUSH; IDLE->RUN on start; RUN->FLUSH when pixel IMG_W*IMG_H-1 is accepted; FLUSH->IDLE when win_valid_out is low or its window is taken, pulsing done in the same cycle.
REQ-015 SHALL ignore start outside IDLE.
REQ-016 SHALL drive pix_ready_out = (state == RUN) && (!win_valid_out || win_ready_in).
REQ-017 SHALL track column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1), both cleared on start; col wraps to 0 and row increments on each accepted pixel with col == IMG_W-1.
REQ-018 SHALL hold two line buffers of IMG_W entries storing the previous two rows, written at index col on every accepted pixel.
REQ-019 SHALL keep a 3x3 shift register; on each accepted pixel, columns shift left and column 2 loads {line buffer 2 [col], line buffer 1 [col], pix_data} as rows 0,1,2.
REQ-020 SHALL set win_valid_out on the cycle after accepting a pixel with row >= 2 and col >= 2 (latency 1 cycle); otherwise clear it when the current window is taken.
REQ-021 SHALL hold win_* and win_valid_out stable while win_valid_out is high and win_ready_in is low.
REQ-022 SHALL produce exactly (IMG_W-2)*(IMG_H-2) windows per frame, no padding, no windows spanning a row wrap.
REQ-023 SHALL permit simultaneous window take and new pixel accept in one cycle, sustaining one window per cycle.

Reset
REQ-024 SHALL on rst low, asynchronously, force state IDLE, col/row 0, all window registers 0, win_valid_out 0, pix_ready_out 0, done 0.
REQ-025 SHALL NOT reset line buffer contents (they are overwritten before use).
REQ-026 SHALL on reset mid-frame discard the frame; the next start begins a clean frame.

Configuration
REQ-027 SHALL, with macro CONV33_WINGEN_CNT_EN defined, add output win_count  output  16  windows taken since the last start, cleared on start, saturating at 16'hFFFF, reset to 0.
REQ-028 SHALL, without CONV33_WINGEN_CNT_EN, have no win_count port and no counter logic, with identical behaviour otherwise.

Verification
REQ-029 SHALL cover IMG_W=IMG_H=4, pixels 1..16, win_ready_in tied high -> 4 windows; first = 1,2,3 / 5,6,7 / 9,10,11; last = 6,7,8 / 10,11,12 / 14,15,16; done pulses once.
REQ-030 SHALL cover same frame with win_ready_in low for 5 cycles at the first window -> window held unchanged, pix_ready_out low throughout, no pixel lost.
REQ-031 SHALL cover rst low after pixel 7 of a 4x4 frame, then start and pixels 1..16 -> outputs identical to REQ-029.
REQ-032 SHALL cover start pulsed during RUN -> ignored; counters unchanged; frame completes normally.
REQ-033 SHALL cover CONV33_WINGEN_CNT_EN defined, 5x5 frame -> win_count reaches 9 at done and returns to 0 on the next start.

Source files
------------

// File: rtl/conv33_window_gen.sv
// conv33_window_gen: streams a raster-order image in and emits every fully
// populated 3x3 neighbourhood (no padding) toward a convolution stage.
// Two line buffers hold the previous two rows. A 3x3 shift register
// assembles the window one column per accepted pixel.
// Optional build macro CONV33_WINGEN_CNT_EN adds a 16-bit saturating
// count of windows taken since the last start (output win_count).
module conv33_window_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  done,
    input  logic                  pix_valid_in,
    output logic                  pix_ready_out,
    input  logic [DATA_WIDTH-1:0] pix_data,
    output logic                  win_valid_out,
    input  logic                  win_ready_in,
    output logic [DATA_WIDTH-1:0] win_0_0,
    output logic [DATA_WIDTH-1:0] win_0_1,
    output logic [DATA_WIDTH-1:0] win_0_2,
    output logic [DATA_WIDTH-1:0] win_1_0,
    output logic [DATA_WIDTH-1:0] win_1_1,
    output logic [DATA_WIDTH-1:0] win_1_2,
    output logic [DATA_WIDTH-1:0] win_2_0,
    output logic [DATA_WIDTH-1:0] win_2_1,
    output logic [DATA_WIDTH-1:0] win_2_2
`ifdef CONV33_WINGEN_CNT_EN
    ,
    output logic [15:0]           win_count
`endif
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                  state_r;
    logic [COL_W-1:0]        col_r;
    logic [ROW_W-1:0]        row_r;
    logic                    win_valid_r;
    logic                    done_r;
    logic [DATA_WIDTH-1:0]   win_r  [3][3];
    logic [DATA_WIDTH-1:0]   lb1_r  [IMG_W];
    logic [DATA_WIDTH-1:0]   lb2_r  [IMG_W];

    logic                    accept_s;
    logic                    take_s;
    logic                    last_col_s;
    logic                    last_row_s;

    // Handshake decode; ready is combinational on downstream ready so a
    // window can be taken and a new pixel accepted in the same cycle.
    assign pix_ready_out = (state_r == RUN) && (!win_valid_r || win_ready_in);
    assign accept_s      = pix_valid_in && pix_ready_out;
    assign take_s        = win_valid_r && win_ready_in;
    assign last_col_s    = (col_r == COL_W'(IMG_W - 1));
    assign last_row_s    = (row_r == ROW_W'(IMG_H - 1));

    // Line buffers: lb1 is the previous row, lb2 the row before it; no reset
    // because every entry is rewritten before a window can use it.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb1_r[col_r] <= pix_data;
            lb2_r[col_r] <= lb1_r[col_r];
        end
    end

    // Frame control FSM, raster counters, window shift register and valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            col_r       <= '0;
            row_r       <= '0;
            win_valid_r <= 1'b0;
            done_r      <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_r[r][c] <= '0;
                end
            end
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r <= RUN;
                        col_r   <= '0;
                        row_r   <= '0;
                    end
                end
                RUN: begin
                    if (accept_s && last_col_s && last_row_s) begin
                        state_r <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (!win_valid_r || take_s) begin
                        state_r <= IDLE;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase

            if (accept_s) begin
                if (last_col_s) begin
                    col_r <= '0;
                    row_r <= last_row_s ? '0 : row_r + ROW_W'(1);
                end else begin
                    col_r <= col_r + COL_W'(1);
                end
                for (int r = 0; r < 3; r++) begin
                    win_r[r][0] <= win_r[r][1];
                    win_r[r][1] <= win_r[r][2];
                end
                win_r[0][2] <= lb2_r[col_r];
                win_r[1][2] <= lb1_r[col_r];
                win_r[2][2] <= pix_data;
                // A window exists only once three rows and three columns of
                // the current row are in, so no window spans a row wrap.
                win_valid_r <= (row_r >= ROW_W'(2)) && (col_r >= COL_W'(2));
            end else if (take_s) begin
                win_valid_r <= 1'b0;
            end
        end
    end

`ifdef CONV33_WINGEN_CNT_EN
    // Saturating count of windows taken since the most recent start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_count <= 16'h0000;
        end else if ((state_r == IDLE) && start) begin
            win_count <= 16'h0000;
        end else if (take_s && (win_count != 16'hFFFF)) begin
            win_count <= win_count + 16'h0001;
        end
    end
`endif

    assign done          = done_r;
    assign win_valid_out = win_valid_r;
    assign win_0_0       = win_r[0][0];
    assign win_0_1       = win_r[0][1];
    assign win_0_2       = win_r[0][2];
    assign win_1_0       = win_r[1][0];
    assign win_1_1       = win_r[1][1];
    assign win_1_2       = win_r[1][2];
    assign win_2_0       = win_r[2][0];
    assign win_2_1       = win_r[2][1];
    assign win_2_2       = win_r[2][2];

endmodule

// File: tb/tb_conv33_window_gen.sv
// Scoreboard bench for conv33_window_gen on a 4x4 image: the driver pushes
// every expected window of a frame (computed directly from the image array)
// and an independent monitor pops and compares on each window handshake.
module tb_conv33_window_gen;

    localparam int DW   = 8;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int N    = W * H;
    localparam int NWIN = (W - 2) * (H - 2);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          done;
    logic          pix_valid_in = 1'b0;
    logic          pix_ready_out;
    logic [DW-1:0] pix_data = '0;
    logic          win_valid_out;
    logic          win_ready_in = 1'b1;
    logic [DW-1:0] w00, w01, w02, w10, w11, w12, w20, w21, w22;
`ifdef CONV33_WINGEN_CNT_EN
    logic [15:0]   win_count;
`endif

    conv33_window_gen #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .start(start), .done(done),
        .pix_valid_in(pix_valid_in), .pix_ready_out(pix_ready_out),
        .pix_data(pix_data), .win_valid_out(win_valid_out),
        .win_ready_in(win_ready_in),
        .win_0_0(w00), .win_0_1(w01), .win_0_2(w02),
        .win_1_0(w10), .win_1_1(w11), .win_1_2(w12),
        .win_2_0(w20), .win_2_1(w21), .win_2_2(w22)
`ifdef CONV33_WINGEN_CNT_EN
        , .win_count(win_count)
`endif
    );

    always #5 clk = ~clk;

    int               n_checks = 0;
    int               n_fail   = 0;
    int               taken    = 0;
    int               done_cnt = 0;
    logic [9*DW-1:0]  exp_q[$];
    logic [9*DW-1:0]  snap;
    bit               stall_pend = 1'b0;
    logic [9*DW-1:0]  cur;

    assign cur = {w00, w01, w02, w10, w11, w12, w20, w21, w22};

    task automatic chk(input string name, input logic [9*DW-1:0] act, input logic [9*DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: window hold during back-pressure, then scoreboard pop on take.
    always @(negedge clk) begin
        if (rst) begin
            if (stall_pend) begin
                chk("hold_valid", {71'd0, win_valid_out}, 72'd1);
                chk("hold_window", cur, snap);
            end
            if (win_valid_out && !win_ready_in) begin
                chk("stall_pix_ready", {71'd0, pix_ready_out}, 72'd0);
                stall_pend = 1'b1;
                snap = cur;
            end else begin
                stall_pend = 1'b0;
            end
            if (win_valid_out && win_ready_in) begin
                chk("window_expected", {71'd0, exp_q.size() != 0}, 72'd1);
                if (exp_q.size() != 0) chk("window", cur, exp_q.pop_front());
                taken++;
            end
            if (done) done_cnt++;
        end else begin
            stall_pend = 1'b0;
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode 0: ready high; 1: random valid/ready; 2: 5-cycle stall at first
    // window; 3: start pulsed mid-frame. seq=1 uses pixels 1..N.
    task automatic run_frame(input int mode, input bit seq);
        logic [DW-1:0]   img[N];
        logic [9*DW-1:0] e;
        int idx, cyc, stall_left, taken0, done0;
        for (int i = 0; i < N; i++) img[i] = seq ? DW'(i + 1) : DW'($urandom_range(0, 255));
        for (int r = 2; r < H; r++)
            for (int c = 2; c < W; c++) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        e[(8 - (i * 3 + j)) * DW +: DW] = img[(r - 2 + i) * W + (c - 2 + j)];
                exp_q.push_back(e);
            end
        taken0 = taken;
        done0  = done_cnt;
        pulse_start();
`ifdef CONV33_WINGEN_CNT_EN
        chk("win_count_cleared", {56'd0, win_count}, 72'd0);
`endif
        idx = 0;
        cyc = 0;
        stall_left = (mode == 2) ? 5 : 0;
        while ((idx < N || done_cnt == done0) && cyc < 2000) begin
            pix_valid_in = (idx < N) && ((mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1);
            pix_data     = (idx < N) ? img[idx] : DW'(0);
            if (mode == 1) begin
                win_ready_in = ($urandom_range(0, 2) != 0);
            end else if (stall_left > 0 && win_valid_out) begin
                win_ready_in = 1'b0;
                stall_left--;
            end else begin
                win_ready_in = 1'b1;
            end
            start = (mode == 3) && (idx == 5);
            @(negedge clk);
            if (pix_valid_in && pix_ready_out) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        pix_valid_in = 1'b0;
        win_ready_in = 1'b1;
        chk("frame_complete", {71'd0, cyc < 2000}, 72'd1);
`ifdef CONV33_WINGEN_CNT_EN
        chk("win_count_at_done", {56'd0, win_count}, 72'(NWIN));
`endif
        repeat (4) @(posedge clk);
        #1;
        chk("done_once", 72'(done_cnt - done0), 72'd1);
        chk("windows_per_frame", 72'(taken - taken0), 72'(NWIN));
        chk("queue_drained", 72'(exp_q.size()), 72'd0);
        chk("idle_pix_ready", {71'd0, pix_ready_out}, 72'd0);
    endtask

    // Start a frame, feed k pixels, then reset in the middle of it.
    task automatic abort_after(input int k);
        int idx, cyc;
        pulse_start();
        idx = 0;
        cyc = 0;
        while (idx < k && cyc < 200) begin
            pix_valid_in = 1'b1;
            pix_data     = DW'(idx + 101);
            @(negedge clk);
            if (pix_ready_out) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("abort_fed", {71'd0, idx == k}, 72'd1);
        pix_valid_in = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_win_valid", {71'd0, win_valid_out}, 72'd0);
        chk("rst_pix_ready", {71'd0, pix_ready_out}, 72'd0);
        chk("rst_done", {71'd0, done}, 72'd0);
        chk("rst_window", cur, 72'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #3;
        chk("reset_win_valid", {71'd0, win_valid_out}, 72'd0);
        chk("reset_pix_ready", {71'd0, pix_ready_out}, 72'd0);
        chk("reset_done", {71'd0, done}, 72'd0);
        chk("reset_window", cur, 72'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        run_frame(0, 1'b1);
        run_frame(2, 1'b1);
        abort_after(7);
        run_frame(0, 1'b1);
        run_frame(3, 1'b1);
        run_frame(3, 1'b0);
        for (int f = 0; f < 6; f++) run_frame(1, 1'b0);
        run_frame(0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
